// File: rtl/mod3_step_scheduler_if.sv
// Requester-side bus of the mod-3 step scheduler: request levels, step counts,
// and the one-hot acknowledge carrying the resulting counter state.
interface mod3_step_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
);
  // req[i] is a level held until ack[i] is sampled; ack is a one-cycle pulse
  // and result/grant_id are meaningful only while ack is nonzero.
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] cnt;
  logic [N_REQ-1:0]   ack;
  logic [1:0]         result;
  logic [IDW-1:0]     grant_id;

  modport master (output req, cnt, input ack, result, grant_id);
  modport slave  (input req, cnt, output ack, result, grant_id);
endinterface

// File: rtl/mod3_step_scheduler.sv
// Round-robin scheduler that drives the shared mod-3 counter's advance line
// for a requested number of cycles and acknowledges with the counter state.
module mod3_step_scheduler #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mod3_step_scheduler_if.slave   bus,
  input  logic [1:0]             state_in,
  output logic                   step,
  output logic                   busy,
  output logic                   sync_err,
  output logic [1:0]             fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    STEP = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_id;
  logic [1:0]     remaining;
  logic [1:0]     shadow;

  logic           found;
  logic [IDW-1:0] winner;
  logic [1:0]     win_cnt;

  // Search from rr_ptr upward, wrapping at N_REQ; first set bit wins.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    win_cnt = 2'b00;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req[idx]) begin
        found   = 1'b1;
        winner  = IDW'(idx);
        win_cnt = bus.cnt[2*idx +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      remaining <= 2'b00;
      shadow    <= 2'b00;
      sync_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id  <= winner;
            remaining <= win_cnt;
            rr_ptr    <= (int'(winner) == N_REQ - 1) ? '0 : winner + IDW'(1);
            state     <= (win_cnt != 2'b00) ? STEP : DONE;
          end
        end
        STEP: begin
          remaining <= remaining - 2'd1;
          // Shadow mirrors the counter and never takes the unused 11 code.
          shadow    <= (shadow == 2'b00) ? 2'b01 : ((shadow == 2'b01) ? 2'b10 : 2'b00);
          if (remaining <= 2'd1) state <= DONE;
        end
        DONE: begin
          if (state_in != shadow) sync_err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode: a reset mid-STEP drops step immediately with the state.
  always_comb begin
    step         = (state == STEP);
    busy         = (state == STEP) || (state == DONE);
    bus.ack      = (state == DONE) ? (N_REQ'(1) << grant_id) : '0;
    bus.result   = (state == DONE) ? state_in : 2'b00;
    bus.grant_id = grant_id;
    fsm_state    = state;
  end

endmodule

// File: doc/mod3_step_scheduler.md
# mod3_step_scheduler

Round-robin scheduler that shares the team's 3-state (mod-3) Moore counter between N requesters. Each requester asks for 0–3 advance steps. The scheduler drives the counter's `in` line for exactly that many cycles, then acknowledges with the resulting counter state. It keeps a shadow copy of the counter state and flags any divergence. It sits directly in front of the counter and is the only driver of that counter's `in`.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `IDW`, default 2: grant-id width; must be at least clog2(N_REQ).
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `req`, input, N_REQ: request level per requester. Held high until that requester's `ack` is sampled.
- `cnt`, input, 2*N_REQ: step count per requester, in bits [2i+1:2i]. Values 0..3; 0 is a pure state read.
- `state_in`, input, 2: counter `state_out` (S0=00, S1=01, S2=10).
- `step`, output, 1: drives the counter `in`.
- `ack`, output, N_REQ: one-hot, one-cycle completion pulse.
- `result`, output, 2: counter state; valid only while `ack` is nonzero.
- `grant_id`, output, IDW: index of the current or last grantee.
- `busy`, output, 1: high in STEP and DONE.
- `sync_err`, output, 1: sticky; set when the shadow state does not match `state_in`.

## Operation
- **FSM states:** IDLE, STEP, DONE. Encoded in a 2-bit register. Outputs are decoded from the state register only (Moore).
- **IDLE:**
  - If `req` is nonzero, arbitrate round-robin. Search starts at `rr_ptr` and wraps modulo N_REQ; the first set bit wins.
  - On the win, latch `grant_id` ← winner, `remaining` ← `cnt[winner]`, and `rr_ptr` ← winner+1 (wrapping to 0).
  - Go to STEP if the latched count is nonzero, else go to DONE.
  - If `req` is zero, stay in IDLE.
- **STEP:**
  - `step`=1.
  - Each cycle, `remaining` ← `remaining`−1 and `shadow` advances 0→1→2→0.
  - When `remaining`==1, go to DONE.
- **DONE:**
  - `ack[grant_id]`=1 and `result`=`state_in`.
  - If `state_in` != `shadow`, set `sync_err`. It clears only on reset.
  - Next state is always IDLE.
- **Requests during a grant:** `req` changes while in STEP or DONE are ignored. `cnt` is sampled only on the grant cycle.
- **Deasserted non-grantee:** a requester that drops `req` before being granted is simply never served. There is no error.
- **Illegal FSM encoding:** go to IDLE with `step`=0.
- **Shadow encoding:** the shadow counter never holds 11.

## Timing
- **Reset values:** state=IDLE, `step`=0, `ack`=0, `result`=00, `grant_id`=0, `busy`=0, `sync_err`=0, `rr_ptr`=0, `shadow`=00, `remaining`=0.
- **Shared reset:** the counter shares `rst`, so both return to S0 together.
- **Latency for count k≥1:**
  - Grant in IDLE cycle T.
  - `step` high in cycles T+1..T+k.
  - The counter updates on the edges closing those cycles.
  - DONE and `ack` in cycle T+k+1, with `result` = the post-step state.
- **Latency for k=0:** `ack` in T+1, `result` = the current state.
- **Minimum spacing:** one IDLE cycle between grants. The back-to-back period is k+2 cycles.
- **Requester handshake:**
  - Drop `req` on the edge that samples `ack`=1, so `req` is low in the following IDLE cycle.
  - A requester that instead keeps `req` high is treated as a new request. It loses priority to others because `rr_ptr` has moved past it.
- **Reset mid-STEP:** `step` falls asynchronously. No `ack` is issued. The aborted request is not remembered.
- **Simultaneous requests:** exactly one grant per IDLE cycle. `ack` is never multi-hot.

## Test plan
1. **Reset:** reset, then single `req[0]`, `cnt`=2. Required: `step` high 2 cycles; `ack[0]` in cycle T+3; `result`=10; `grant_id`=0; `sync_err`=0.
2. **Wrap-around:** from S0, `req[1]` `cnt`=3. Required: `result`=00, and `shadow` matches.
3. **Arbitration:** all four `req` high, each `cnt`=1, each dropped after its ack. Required:
   - grant order 0,1,2,3;
   - results 01,10,00,01;
   - grants at cycles T, T+3, T+6, T+9.
4. **Read-only:** `cnt`=0 in state S2. Required: `step` never high; `ack` at T+1 with `result`=10.
5. **Divergence:** force `state_in` to 00 after a `cnt`=1 request from S0. Required: `sync_err`=1 at DONE, and it stays high through later requests until `rst`.
6. **Abort:** assert `rst` low during the 2nd STEP cycle of a `cnt`=3 request. Required: all outputs at reset values immediately; after release, `req[2]` `cnt`=1 gives `result`=01 and `grant_id`=2.
